// File: rtl/nmea_sentence_filter_if.sv
// Byte path between uart_rx and the FIFO write port; the filter is the slave.
interface nmea_sentence_filter_if;
    logic [7:0] uart_data;
    logic       byte_received;
    logic       fifo_full;
    logic [7:0] out_data;
    logic       out_valid;

    modport master (output uart_data, byte_received, fifo_full,
                    input  out_data, out_valid);
    modport slave  (input  uart_data, byte_received, fifo_full,
                    output out_data, out_valid);
endinterface

// File: rtl/nmea_sentence_filter.sv
// Frames NMEA sentences, verifies the XOR checksum and forwards only valid
// sentences to the FIFO; enable=0 gives raw passthrough.
module nmea_sentence_filter #(
    parameter int MAX_LEN = 82
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    nmea_sentence_filter_if.slave bus,
    output logic                  sentence_done,
    output logic [15:0]           good_count,
    output logic [15:0]           bad_count,
    output logic [15:0]           drop_count
);
    localparam int PW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {HUNT, BODY, CK_HI, CK_LO, EXP_CR, EXP_LF, DRAIN} state_t;

    state_t        r_state;
    logic [7:0]    r_buf [MAX_LEN];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [7:0]    r_ck;
    logic [7:0]    r_hex;
    logic          r_done;
    logic [15:0]   r_good;
    logic [15:0]   r_bad;
    logic [15:0]   r_drop;

    logic [7:0]    w_byte;
    logic [4:0]    w_hex;
    logic          w_pass;
    logic          w_drain_wr;
    logic          w_last;
    logic          w_room;
    logic          w_restart;
    logic          w_store;
    logic          w_err;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // {valid, nibble}; only uppercase hex digits are legal.
    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
        if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
        return 5'd0;
    endfunction

    assign w_byte     = bus.uart_data;
    assign w_hex      = hex_nib(w_byte);
    assign w_pass     = (r_state == HUNT) && !enable;
    assign w_drain_wr = (r_state == DRAIN) && !bus.fifo_full;
    assign w_last     = (r_rd_ptr == r_wr_ptr - PW'(1));
    assign w_room     = (r_wr_ptr < PW'(MAX_LEN));

    assign bus.out_valid = w_pass ? (bus.byte_received && !bus.fifo_full) : w_drain_wr;
    assign bus.out_data  = w_pass ? (bus.byte_received ? w_byte : 8'h00)
                         : (r_state == DRAIN) ? r_buf[r_rd_ptr[AW-1:0]] : 8'h00;

    assign sentence_done = r_done;
    assign good_count    = r_good;
    assign bad_count     = r_bad;
    assign drop_count    = r_drop;

    always_comb begin
        w_restart = 1'b0;
        w_store   = 1'b0;
        w_err     = 1'b0;
        if (!w_pass && r_state != DRAIN && bus.byte_received) begin
            case (r_state)
                HUNT: w_restart = (w_byte == 8'h24);
                BODY: begin
                    if (w_byte == 8'h24) w_restart = 1'b1;
                    else if (!w_room || w_byte < 8'h20 || w_byte > 8'h7E) w_err = 1'b1;
                    else w_store = 1'b1;
                end
                CK_HI, CK_LO: begin
                    if (!w_room || !w_hex[4]) w_err = 1'b1;
                    else w_store = 1'b1;
                end
                EXP_CR: begin
                    if (!w_room || w_byte != 8'h0D) w_err = 1'b1;
                    else w_store = 1'b1;
                end
                EXP_LF: begin
                    if (!w_room || w_byte != 8'h0A || r_hex != r_ck) w_err = 1'b1;
                    else w_store = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_restart) r_buf[0] <= w_byte;
        else if (w_store) r_buf[r_wr_ptr[AW-1:0]] <= w_byte;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= HUNT;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_done   <= 1'b0;
            r_good   <= '0;
            r_bad    <= '0;
            r_drop   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_pass) begin
                if (bus.byte_received && bus.fifo_full) r_drop <= sat_inc(r_drop);
            end else if (r_state == DRAIN) begin
                // Bytes arriving while draining are lost; the framer resumes in HUNT.
                if (bus.byte_received) r_drop <= sat_inc(r_drop);
                if (w_drain_wr) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                    if (w_last) begin
                        r_good   <= sat_inc(r_good);
                        r_done   <= 1'b1;
                        r_wr_ptr <= '0;
                        r_state  <= HUNT;
                    end
                end
            end else if (w_restart) begin
                if (r_state != HUNT) r_bad <= sat_inc(r_bad);
                r_wr_ptr <= PW'(1);
                r_ck     <= 8'h00;
                r_state  <= BODY;
            end else if (w_err) begin
                r_bad    <= sat_inc(r_bad);
                r_wr_ptr <= '0;
                r_state  <= HUNT;
            end else if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                case (r_state)
                    BODY: begin
                        if (w_byte == 8'h2A) r_state <= CK_HI;
                        else r_ck <= r_ck ^ w_byte;
                    end
                    CK_HI: begin
                        r_hex[7:4] <= w_hex[3:0];
                        r_state    <= CK_LO;
                    end
                    CK_LO: begin
                        r_hex[3:0] <= w_hex[3:0];
                        r_state    <= EXP_CR;
                    end
                    EXP_CR: r_state <= EXP_LF;
                    EXP_LF: begin
                        r_rd_ptr <= '0;
                        r_state  <= DRAIN;
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_nmea_sentence_filter.sv
// Directed bench for nmea_sentence_filter (default MAX_LEN plus an 8-byte instance).
module tb_nmea_sentence_filter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        done_a, done_b;
    logic [15:0] good_a, bad_a, drop_a;
    logic [15:0] good_b, bad_b, drop_b;

    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [7:0]  q[$];
    int          qc[$];
    logic [7:0]  q8[$];

    nmea_sentence_filter_if bus();
    nmea_sentence_filter_if bus8();

    assign bus8.uart_data     = bus.uart_data;
    assign bus8.byte_received = bus.byte_received;
    assign bus8.fifo_full     = bus.fifo_full;

    nmea_sentence_filter dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus),
        .sentence_done(done_a), .good_count(good_a), .bad_count(bad_a), .drop_count(drop_a)
    );

    nmea_sentence_filter #(.MAX_LEN(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus8),
        .sentence_done(done_b), .good_count(good_b), .bad_count(bad_b), .drop_count(drop_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid) begin
            q.push_back(bus.out_data);
            qc.push_back(cyc);
        end
        if (bus8.out_valid) q8.push_back(bus8.out_data);
        if (done_a) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.uart_data     = b;
        bus.byte_received = 1'b1;
        @(posedge clk);
        #1;
        bus.byte_received = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic check_q(input string tag, input string exp);
        check({tag, "_len"}, q.size(), exp.len());
        for (int i = 0; i < exp.len(); i++)
            check(tag, (i < q.size()) ? {24'd0, q[i]} : 32'hFFFF, {24'd0, exp[i]});
    endtask

    task automatic clear_caps();
        q.delete();
        qc.delete();
        q8.delete();
        done_cnt = 0;
    endtask

    initial begin
        bus.uart_data     = 8'h00;
        bus.byte_received = 1'b0;
        bus.fifo_full     = 1'b0;

        // Reset state
        idle(2);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_data", bus.out_data, 8'h00);
        check("rst_cnt", {good_a, bad_a}, 32'd0);
        reset_n = 1'b1;

        // Valid sentence drains on consecutive cycles right after LF
        clear_caps();
        send_str("$A*41\015\012");
        check("first_valid", bus.out_valid, 1'b1);
        check("first_data", bus.out_data, 8'h24);
        idle(10);
        check_q("s1", "$A*41\015\012");
        check("s1_span", (qc.size() == 7) ? qc[6] - qc[0] : -1, 6);
        check("s1_good", good_a, 16'd1);
        check("s1_pulses", done_cnt, 1);
        check("s1_done_cyc", done_cyc, (qc.size() == 7) ? qc[6] + 1 : -1);

        // Bad checksum and lowercase hex
        clear_caps();
        send_str("$A*42\015\012");
        check("bad1", bad_a, 16'd1);
        send_str("$a*3b\015\012");
        idle(5);
        check("bad_nowrite", q.size(), 0);
        check("bad2", bad_a, 16'd2);
        check("bad_good", good_a, 16'd1);

        // Overflow on the 8-byte instance
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        clear_caps();
        send_str("$ABCDEF*");
        check("ovf_pre", bad_b, 16'd0);
        send_byte(8'h2E);
        check("ovf_9th", bad_b, 16'd1);
        send_byte(8'h2E);
        send_str("$AB*03\015\012");
        idle(10);
        check("max8_good", good_b, 16'd1);
        check("max8_len", q8.size(), 8);
        check("max8_last", (q8.size() == 8) ? q8[7] : 8'hFF, 8'h0A);
        check("max8_bad", bad_b, 16'd1);

        // FIFO full for 5 cycles mid-drain with a strobe during the stall
        clear_caps();
        send_str("$A*41\015\012");
        idle(2);
        bus.fifo_full     = 1'b1;
        bus.uart_data     = 8'h58;
        bus.byte_received = 1'b1;
        #1;
        check("stall_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        bus.byte_received = 1'b0;
        idle(4);
        bus.fifo_full = 1'b0;
        idle(10);
        check_q("stall", "$A*41\015\012");
        check("stall_gap", (qc.size() == 7) ? qc[2] - qc[1] : -1, 6);
        check("stall_span", (qc.size() == 7) ? qc[6] - qc[0] : -1, 11);
        check("stall_drop", drop_a, 16'd1);
        check("stall_good", good_a, 16'd2);

        // Reset mid-drain, then mid-sentence
        send_str("$A*41\015\012");
        idle(2);
        reset_n = 1'b0;
        idle(1);
        check("rst_drain_valid", bus.out_valid, 1'b0);
        check("rst_drain_good", good_a, 16'd0);
        reset_n = 1'b1;
        send_str("$GP");
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        clear_caps();
        send_str("$A*41\015\012");
        idle(10);
        check_q("after_rst", "$A*41\015\012");
        check("after_rst_cnt", {good_a, bad_a}, {16'd1, 16'd0});
        check("after_rst_drop", drop_a, 16'd0);
        check("after_rst_pulse", done_cnt, 1);

        // Passthrough: zero latency, drop while full
        enable            = 1'b0;
        bus.uart_data     = 8'h00;
        bus.byte_received = 1'b1;
        #1;
        check("pt0_valid", bus.out_valid, 1'b1);
        check("pt0_data", bus.out_data, 8'h00);
        @(posedge clk);
        #1;
        bus.uart_data = 8'hFF;
        #1;
        check("ptFF_valid", bus.out_valid, 1'b1);
        check("ptFF_data", bus.out_data, 8'hFF);
        @(posedge clk);
        #1;
        bus.uart_data = 8'h24;
        bus.fifo_full = 1'b1;
        #1;
        check("pt_full_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        bus.byte_received = 1'b0;
        bus.fifo_full     = 1'b0;
        check("pt_drop", drop_a, 16'd1);
        enable = 1'b1;
        send_str("A*41\015\012");
        idle(5);
        check("pt_framer_held", {good_a, bad_a}, {16'd1, 16'd0});

        // Mode change mid-sentence is deferred until HUNT
        clear_caps();
        send_str("$A*41\015");
        enable = 1'b0;
        send_byte(8'h0A);
        idle(10);
        check_q("defer", "$A*41\015\012");
        check("defer_good", good_a, 16'd2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/nmea_sentence_filter.md
# nmea_sentence_filter

Sits between `uart_rx` (GNSS receive path) and the 8-bit write side of the UART Rx FIFO. It frames the raw byte stream from the CAM-M8Q into NMEA sentences (`$`…`*hh<CR><LF>`) and verifies each sentence's XOR checksum. Only complete, valid sentences are forwarded to the FIFO, so host PipeOut reads never contain partial or corrupt sentences. A bypass input restores raw byte passthrough, and saturating counters expose link quality through WireOuts.

## Interface
Parameters:
- `MAX_LEN`, 82: maximum stored sentence length in bytes, from `$` through `<LF>` inclusive.

Ports:
- `clk`  in  1  — system clock (okClk domain).
- `reset_n`  in  1  — synchronous, active-low reset.
- `enable`  in  1  — 1 = filter mode; 0 = raw passthrough.
- `uart_data`  in  8  — received byte from `uart_rx`.
- `byte_received`  in  1  — one-cycle strobe qualifying `uart_data`.
- `fifo_full`  in  1  — FIFO full flag.
- `out_data`  out  8  — byte to FIFO `din`.
- `out_valid`  out  1  — FIFO `wr_en`.
- `sentence_done`  out  1  — one-cycle pulse after the last byte of a sentence is written.
- `good_count`  out  16  — valid sentences forwarded; saturating.
- `bad_count`  out  16  — sentences rejected; saturating.
- `drop_count`  out  16  — input bytes discarded; saturating.

## Operation
- Storage: `MAX_LEN` × 8 buffer, asynchronous read. Write pointer is `wr_ptr`, read pointer is `rd_ptr`. Running checksum is `ck` (8 bits).
- States: HUNT, BODY, CK_HI, CK_LO, EXP_CR, EXP_LF, DRAIN.
- HUNT: a `$` stores the byte and sets `wr_ptr`=1, `ck`=0, then moves to BODY. All other bytes are ignored and are not counted.
- BODY:
  - `*` is stored, then CK_HI.
  - `$` is an abort: `bad_count`++, restart the sentence with this `$`, stay in BODY.
  - A byte <0x20 or >0x7E is an error.
  - Any other byte is stored and `ck ^= byte`.
- CK_HI / CK_LO: accept only `0`–`9` and `A`–`F`; lowercase is an error. Each digit is stored and its nibble is latched. The sequence is CK_HI → CK_LO → EXP_CR.
- EXP_CR: requires 0x0D, then EXP_LF. EXP_LF: requires 0x0A.
- On a correct LF:
  - If latched hex == `ck`, go to DRAIN with `rd_ptr`=0.
  - Otherwise, error.
- Error (any state): `bad_count`++, discard the buffer, return to HUNT. The offending byte is not re-examined.
- Overflow: a byte that would make the length exceed `MAX_LEN` is an error.
- DRAIN:
  - `out_valid` = !`fifo_full` (combinational); `out_data` = buf[`rd_ptr`].
  - `rd_ptr` advances on each cycle with `out_valid`=1.
  - After the byte at `wr_ptr`-1 is written: `good_count`++, pulse `sentence_done`, return to HUNT.
- Any `byte_received` during DRAIN: `drop_count`++, byte discarded. Filtering resumes in HUNT, so the interrupted sentence is lost.
- Passthrough (`enable`=0):
  - `out_valid` = `byte_received` & !`fifo_full`; `out_data` = `uart_data`.
  - A byte arriving while full: `drop_count`++.
  - The framer is held in HUNT and counters other than `drop_count` are frozen.
- Mode changes take effect only in HUNT or while passthrough is active. A change of `enable` during BODY..DRAIN is deferred until the framer returns to HUNT.
- Counters saturate at 0xFFFF and are cleared only by reset.

## Timing
- Reset (`reset_n`=0 at a rising edge):
  - State HUNT, all pointers 0.
  - `out_valid`=0, `sentence_done`=0, `out_data`=0x00.
  - All counters 0.
  - Applies mid-sentence and mid-DRAIN; the partial output is simply abandoned.
- Each input byte is consumed in the cycle its strobe is high. State and counters update at that edge.
- The first DRAIN write occurs in the cycle after the edge that accepted LF, if `fifo_full`=0.
- An N-byte sentence drains in N cycles when the FIFO is never full. Each full cycle adds one cycle of stall with no write.
- `sentence_done` is asserted in the cycle after the last write.
- Passthrough latency is 0 cycles (combinational).

## Test plan
- Filter on, send `$A*41\r\n`: FIFO receives 24 41 2A 34 31 0D 0A on 7 consecutive cycles; `good_count`=1, one `sentence_done` pulse.
- Send `$A*42\r\n`, then `$a*3b\r\n`: nothing written; `bad_count`=2. The second is rejected on lowercase hex.
- `MAX_LEN`=8, send `$ABCDEF*..`: rejected at the 9th byte, `bad_count`=1. Then `$AB*03\r\n` (exactly 8 bytes) is forwarded.
- Valid sentence with `fifo_full` held high for 5 cycles mid-drain: no writes while full, exact byte order preserved, drain completes 5 cycles late. A strobe injected during the stall gives `drop_count`=1.
- Assert `reset_n`=0 after `$GP`, then send `$A*41\r\n`: only the second sentence appears and all counters read 0 except `good_count`=1.
- `enable`=0, stream 0x00, 0xFF, `$`: all 3 bytes pass with zero latency. With `fifo_full`=1 on one of them, that byte is dropped and `drop_count`=1.
